// File: rtl/arm_ram_model.sv
// arm_ram_model
//   Word-organised RAM behind the ARMv4 core's memory port. Each request is
//   accepted in IDLE and then held for a fixed number of cycles. After that the
//   model completes the access with a single-cycle ram_ready pulse, which gives
//   the core's wait-state path genuine stalls to exercise.
//
// Ports
//   clk                clock, rising edge
//   rst                synchronous active-high reset (memory contents are kept)
//   cs, oe, we         chip select, read request, write request (we wins over oe)
//   address[31:0]      byte address; [ADDR_BITS+1:2] word index, [1:0] write lanes
//   data_size[1:0]     00 byte, 01 halfword, 10/11 word
//   ram_data_in[31:0]  right-justified store data
//   ram_data_into_mcu  full aligned word of the last completed access
//   ram_ready          one-cycle completion pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for cs & (we | oe); request fields latched on accept
// WAIT  | latency down-counter running; leaves when it reads zero
// RESP  | ram_ready high for one cycle, then back to IDLE
module arm_ram_model #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        oe,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [1:0]  data_size,
    input  logic [31:0] ram_data_in,
    output logic [31:0] ram_data_into_mcu,
    output logic        ram_ready
);

    localparam int       DEPTH  = 2 ** ADDR_BITS;
    localparam bit [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [1:0]             lane_q;
    logic [1:0]             size_q;
    logic [31:0]            din_q;
    logic                   wr_q;
    logic [31:0]            dout_q;
    logic                   accept;
    logic                   commit;

    logic [31:0]            cur_word;
    logic [3:0]             lane_mask;
    logic [31:0]            lane_data;
    logic [31:0]            merged;

    // Contents start at zero and survive rst.
    logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};

    // Address bits above the word index alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADDR_BITS+2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        commit    = 1'b0;
        ram_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs && (we || oe)) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                ram_ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Store data is replicated across the lanes so that the lane mask alone picks the target bytes.
    always_comb begin
        cur_word = mem[idx_q];
        case (size_q)
            2'b00: begin
                lane_mask = 4'b0001 << lane_q;
                lane_data = {4{din_q[7:0]}};
            end
            2'b01: begin
                lane_mask = lane_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{din_q[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = din_q;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = lane_mask[i] ? lane_data[8*i +: 8] : cur_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            din_q   <= 32'h0;
            wr_q    <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q  <= address[ADDR_BITS+1:2];
                lane_q <= address[1:0];
                size_q <= data_size;
                din_q  <= ram_data_in;
                wr_q   <= we;
            end
            if (commit) begin
                dout_q <= wr_q ? merged : cur_word;
            end
        end
    end

    // A reset that coincides with the commit edge aborts the store.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q) begin
            mem[idx_q] <= merged;
        end
    end

    assign ram_data_into_mcu = dout_q;

endmodule

// File: tb/tb_arm_ram_model.sv
module tb_arm_ram_model;

    localparam int AB  = 12;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, oe = 1'b0, we = 1'b0;
    logic [31:0] address = 32'h0;
    logic [1:0]  data_size = 2'b10;
    logic [31:0] ram_data_in = 32'h0;
    logic [31:0] ram_data_into_mcu;
    logic        ram_ready;

    arm_ram_model #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .cs                (cs),
        .oe                (oe),
        .we                (we),
        .address           (address),
        .data_size         (data_size),
        .ram_data_in       (ram_data_in),
        .ram_data_into_mcu (ram_data_into_mcu),
        .ram_ready         (ram_ready)
    );

    always #5 clk = ~clk;

    int cmp_count = 0;
    int mis_count = 0;
    int pulses    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_count++;
        if (act !== req) begin
            mis_count++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model. Each access is treated as an event that completes a fixed LAT edges after it is accepted.
    logic [31:0] mref [0:(1<<AB)-1];
    int          edge_n    = 0;
    int          next_free = 0;
    int          done_edge = 0;
    bit          pending   = 0;
    logic [AB-1:0] m_idx;
    logic [1:0]  m_lane, m_size;
    logic [31:0] m_data;
    bit          m_w;
    logic        exp_ready = 1'b0;
    logic [31:0] exp_data  = 32'h0;

    initial begin
        for (int i = 0; i < (1<<AB); i++) mref[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            pending   = 0;
            next_free = 0;
            exp_ready = 1'b0;
            exp_data  = 32'h0;
        end else begin
            exp_ready = 1'b0;
            if (pending && edge_n == done_edge) begin
                if (m_w) begin
                    for (int b = 0; b < 4; b++) begin
                        bit hit;
                        logic [7:0] v;
                        if (m_size == 2'b00) begin
                            hit = (b == int'(m_lane));
                            v   = m_data[7:0];
                        end else if (m_size == 2'b01) begin
                            hit = ((b / 2) == int'(m_lane[1]));
                            v   = m_data[8*(b%2) +: 8];
                        end else begin
                            hit = 1;
                            v   = m_data[8*b +: 8];
                        end
                        if (hit) mref[m_idx][8*b +: 8] = v;
                    end
                end
                exp_data  = mref[m_idx];
                exp_ready = 1'b1;
                pending   = 0;
            end
            if (edge_n >= next_free && cs && (we || oe)) begin
                m_idx     = address[AB+1:2];
                m_lane    = address[1:0];
                m_size    = data_size;
                m_data    = ram_data_in;
                m_w       = we;
                pending   = 1;
                done_edge = edge_n + LAT;
                next_free = edge_n + LAT + 2;
            end
        end
        edge_n++;
    end

    always @(negedge clk) begin
        check("ready_vs_model", {31'h0, ram_ready}, {31'h0, exp_ready});
        check("data_vs_model", ram_data_into_mcu, exp_data);
        if (ram_ready === 1'b1) pulses++;
    end

    task automatic access(input logic w, input logic o, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d, input bit perturb,
                          output logic [31:0] rd, output int lat);
        cs = 1'b1; we = w; oe = o; address = a; data_size = sz; ram_data_in = d;
        lat = 0;
        rd  = 32'h0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (perturb && n <= 2) begin
                cs = 1'b1;
                we = 1'($urandom);
                oe = 1'($urandom);
                address = $urandom;
                ram_data_in = $urandom;
                data_size = 2'($urandom);
            end else begin
                cs = 1'b0;
            end
            if (ram_ready === 1'b1) begin
                lat = n;
                rd  = ram_data_into_mcu;
                break;
            end
        end
        cs = 1'b0;
        if (lat == 0) check("access_timeout", 32'd0, 32'd1);
        else check("access_latency", 32'(lat), 32'(LAT + 1));
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          lat;
    int          p0;

    initial begin
        // Reset, with a request held active
        cs = 1'b1; oe = 1'b1; we = 1'b0; rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_ready", {31'h0, ram_ready}, 32'h0);
            check("reset_data", ram_data_into_mcu, 32'h0);
        end
        rst = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ram_ready === 1'b1) begin lat = n; break; end
        end
        cs = 1'b0; oe = 1'b0;
        check("first_pulse_latency", 32'(lat), 32'd4);
        repeat (2) @(negedge clk);

        // Word write, then read
        p0 = pulses;
        access(1'b1, 1'b0, 32'h100, 2'b10, 32'hDEADBEEF, 0, rd, lat);
        check("word_write_data", rd, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'h100, 2'b10, 32'h0, 0, rd, lat);
        check("word_read_data", rd, 32'hDEADBEEF);
        check("word_pulse_count", 32'(pulses - p0), 32'd2);

        // Byte and halfword lanes
        access(1'b1, 1'b0, 32'h102, 2'b00, 32'hFFFFFF11, 0, rd, lat);
        check("byte_write_data", rd, 32'hDE11BEEF);
        access(1'b1, 1'b0, 32'h101, 2'b01, 32'hFFFF2233, 0, rd, lat);
        access(1'b0, 1'b1, 32'h100, 2'b00, 32'h0, 0, rd, lat);
        check("lane_read_data", rd, 32'hDE112233);

        // Reset while the write is waiting
        p0 = pulses;
        cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'h200; data_size = 2'b10;
        ram_data_in = 32'h12345678;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_pulse", 32'(pulses - p0), 32'd0);
        access(1'b0, 1'b1, 32'h200, 2'b10, 32'h0, 0, rd, lat);
        check("abort_no_write", rd, 32'h0);

        // Aliasing, and we taking priority over oe
        access(1'b1, 1'b1, 32'h4000, 2'b10, 32'hA5A5A5A5, 0, rd, lat);
        access(1'b0, 1'b1, 32'h0000, 2'b10, 32'h0, 0, rd, lat);
        check("alias_read", rd, 32'hA5A5A5A5);

        // Inputs changing while the access is in flight
        access(1'b1, 1'b0, 32'h300, 2'b10, 32'hCAFEF00D, 1, rd, lat);
        check("isolation_write", rd, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'h300, 2'b10, 32'h0, 0, rd, lat);
        check("isolation_read", rd, 32'hCAFEF00D);

        // Chip select low
        p0 = pulses;
        cs = 1'b0; we = 1'b1; oe = 1'b1;
        repeat (10) begin
            address = $urandom;
            ram_data_in = $urandom;
            @(negedge clk);
        end
        check("cs_low_no_pulse", 32'(pulses - p0), 32'd0);
        we = 1'b0; oe = 1'b0;

        // Random traffic. Addresses are confined to 16 words so that accesses
        // collide, and the high bits are left random so that aliasing is exercised.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            cs          = ($urandom_range(0, 3) != 0);
            we          = 1'($urandom);
            oe          = 1'($urandom);
            address     = $urandom & 32'hFFFF_C03F;
            data_size   = 2'($urandom);
            ram_data_in = $urandom;
            @(negedge clk);
        end
        rst = 1'b0; cs = 1'b0;
        repeat (LAT + 3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
        $finish;
    end

endmodule
